fir_mac_scheduler: RTL and testbench

- Time-multiplexed tap controller for the FIR datapath.
- Accepts input samples over a valid/ready stream and holds the sample delay line and the coefficient bank.
- Shares one WIDTH x WIDTH multiplier across all taps, one tap per cycle, and fills a product register bank.
- Presents the bank as a flattened bus to the external sum tree, captures its sum, and returns the result on an output valid/ready stream.

---
 rtl/fir_mac_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed tap controller for an 8-tap FIR.
// Accepts one sample per computation over a valid/ready stream, shifts it
// into the delay line, runs one shared WIDTHxWIDTH multiply per cycle to fill
// the product bank, captures the external sum tree result and returns it on
// an output valid/ready stream.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   coef_we/addr/data       coefficient bank write (accepted only in IDLE)
//   s_valid/s_ready/s_data  input sample stream
//   prod_flat               registered product bank, tap k at [PWIDTH*(k+1)-1 -: PWIDTH]
//   sum_in                  signed sum of prod_flat from the external sum tree
//   m_valid/m_ready/m_data  output result stream
//   busy                    high whenever the controller is not in IDLE
//
// Optional feature (macro FIR_MAC_COEF_ERR_EN): adds coef_err (sticky flag
// for dropped coefficient writes) and coef_err_clr (clears it on next edge).
module fir_mac_scheduler #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned PWIDTH = 2 * WIDTH,
    parameter int unsigned AW     = $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_we,
    input  logic [AW-1:0]              coef_addr,
    input  logic signed [WIDTH-1:0]    coef_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [WIDTH-1:0]    s_data,
    output logic [PWIDTH*TAPS-1:0]     prod_flat,
    input  logic signed [PWIDTH+3:0]   sum_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [PWIDTH+3:0]   m_data,
`ifdef FIR_MAC_COEF_ERR_EN
    output logic                       coef_err,
    input  logic                       coef_err_clr,
`endif
    output logic                       busy
);

    localparam int unsigned SWIDTH = PWIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_SUM  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic signed [WIDTH-1:0]   r_delay [TAPS];
    logic signed [WIDTH-1:0]   r_coef  [TAPS];
    logic signed [PWIDTH-1:0]  r_prod  [TAPS];
    logic [AW-1:0]             r_k;
    logic signed [SWIDTH-1:0]  r_m_data;
    logic                      r_m_valid;
    logic                      r_busy;

    logic                      w_accept;
    logic                      w_coef_wr;
    logic                      w_coef_drop;
    logic                      w_addr_ok;
    logic signed [WIDTH-1:0]   w_mul_a;
    logic signed [WIDTH-1:0]   w_mul_b;
    logic signed [PWIDTH-1:0]  w_mul_p;

    assign w_addr_ok = (32'(coef_addr) < TAPS);

    // Shared multiplier: operands selected by the running tap index
    assign w_mul_a = r_delay[r_k];
    assign w_mul_b = r_coef[r_k];
    assign w_mul_p = PWIDTH'(w_mul_a) * PWIDTH'(w_mul_b);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_coef_wr   = 1'b0;
        w_coef_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept    = s_valid;
                w_coef_wr   = coef_we & w_addr_ok;
                w_coef_drop = coef_we & ~w_addr_ok;
                if (s_valid) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                w_coef_drop = coef_we;
                if (r_k == AW'(TAPS - 1)) begin
                    w_state_nxt = S_SUM;
                end
            end
            S_SUM: begin
                w_coef_drop = coef_we;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                w_coef_drop = coef_we;
                if (m_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: delay line, coefficient bank, product bank, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                r_delay[i] <= '0;
                r_coef[i]  <= '0;
                r_prod[i]  <= '0;
            end
            r_k       <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Coefficient write and sample accept may share an edge; MAC
            // starts on the following cycle and so sees the new coefficient.
            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_data;
            end
            if (w_accept) begin
                r_delay[0] <= s_data;
                for (int i = 1; i < int'(TAPS); i++) begin
                    r_delay[i] <= r_delay[i-1];
                end
                r_k    <= '0;
                r_busy <= 1'b1;
            end
            if (r_state == S_MAC) begin
                r_prod[r_k] <= w_mul_p;
                r_k         <= r_k + AW'(1);
            end
            if (r_state == S_SUM) begin
                r_m_data  <= sum_in;
                r_m_valid <= 1'b1;
            end
            if (r_state == S_OUT && m_ready) begin
                r_m_valid <= 1'b0;
                r_busy    <= 1'b0;
            end
        end
    end

`ifdef FIR_MAC_COEF_ERR_EN
    logic r_coef_err;

    // Sticky dropped-write flag; a new drop outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef_err <= 1'b0;
        end else if (w_coef_drop) begin
            r_coef_err <= 1'b1;
        end else if (coef_err_clr) begin
            r_coef_err <= 1'b0;
        end
    end

    assign coef_err = r_coef_err;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_coef_drop;
`endif

    // Flatten product bank for the sum tree
    for (genvar g = 0; g < int'(TAPS); g++) begin : g_flat
        assign prod_flat[PWIDTH*(g+1)-1 -: PWIDTH] = r_prod[g];
    end

    assign s_ready = (r_state == S_IDLE);
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Testbench for fir_mac_scheduler: directed and random samples checked
// against an arithmetic reference model of the filter.
module tb_fir_mac_scheduler;

    localparam int TAPS   = 8;
    localparam int WIDTH  = 16;
    localparam int PWIDTH = 32;

    logic                      clk;
    logic                      rst_n;
    logic                      coef_we;
    logic [2:0]                coef_addr;
    logic signed [WIDTH-1:0]   coef_data;
    logic                      s_valid;
    logic                      s_ready;
    logic signed [WIDTH-1:0]   s_data;
    logic [PWIDTH*TAPS-1:0]    prod_flat;
    logic signed [PWIDTH+3:0]  sum_in;
    logic                      m_valid;
    logic                      m_ready;
    logic signed [PWIDTH+3:0]  m_data;
    logic                      busy;
`ifdef FIR_MAC_COEF_ERR_EN
    logic                      coef_err;
    logic                      coef_err_clr;
`endif

    int total = 0;
    int bad   = 0;

    longint m_coef [TAPS];
    longint m_dly  [TAPS];

    fir_mac_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .prod_flat (prod_flat),
        .sum_in    (sum_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef FIR_MAC_COEF_ERR_EN
        .coef_err     (coef_err),
        .coef_err_clr (coef_err_clr),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External sum tree: plain signed addition of the eight taps
    always_comb begin
        logic signed [PWIDTH+3:0] acc;
        logic signed [PWIDTH-1:0] t;
        acc = '0;
        for (int i = 0; i < TAPS; i++) begin
            t   = prod_flat[i*PWIDTH +: PWIDTH];
            acc = acc + 36'(t);
        end
        sum_in = acc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag, input logic [PWIDTH*TAPS-1:0] obs,
                            input logic [PWIDTH*TAPS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint exp_sum();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += m_dly[i] * m_coef[i];
        return s;
    endfunction

    function automatic logic [PWIDTH*TAPS-1:0] exp_bank();
        logic [PWIDTH*TAPS-1:0] b = '0;
        for (int i = 0; i < TAPS; i++) b[i*PWIDTH +: PWIDTH] = 32'(m_dly[i] * m_coef[i]);
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_dly[i]  = 0;
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [WIDTH-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        step();
        coef_we   = 1'b0;
        m_coef[a] = d;
    endtask

    // One full sample: accept, wait for the result, optionally stall, handshake
    task automatic run_sample(input logic signed [WIDTH-1:0] val, input int hold,
                              input bit sim_wr, input bit junk_wr);
        int n;
        int lat;
        int lowcnt;
        logic [2:0] a;
        logic signed [WIDTH-1:0] d;
        logic signed [PWIDTH+3:0] held;
        s_valid = 1'b1;
        s_data  = val;
        m_ready = 1'b0;
        n = 0;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        chk("s_ready_idle", 64'(s_ready), 1);
        if (sim_wr) begin
            a = 3'($urandom_range(0, TAPS - 1));
            d = 16'($urandom);
            coef_we   = 1'b1;
            coef_addr = a;
            coef_data = d;
            m_coef[a] = d;
        end
        step();
        s_valid = 1'b0;
        coef_we = 1'b0;
        s_data  = 16'($urandom);
        for (int i = TAPS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = val;
        lat    = 0;
        lowcnt = 0;
        while (!m_valid && lat < 50) begin
            if (!s_ready) lowcnt++;
            if (junk_wr) begin
                coef_we   = 1'b1;
                coef_addr = 3'd2;
                coef_data = 16'sd7;
            end
            step();
            lat++;
        end
        coef_we = 1'b0;
        chk("latency", lat, TAPS + 1);
        chk("busy_out", 64'(busy), 1);
        chk("m_data", m_data, exp_sum());
        chk_bank("prod_flat", prod_flat, exp_bank());
`ifdef FIR_MAC_COEF_ERR_EN
        if (junk_wr) chk("coef_err_set", 64'(coef_err), 1);
`endif
        held = m_data;
        for (int h = 0; h < hold; h++) begin
            if (!s_ready) lowcnt++;
            step();
            chk("hold_valid", 64'(m_valid), 1);
            chk("hold_data", m_data, held);
            chk("hold_s_ready", 64'(s_ready), 0);
        end
        if (!s_ready) lowcnt++;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("s_ready_low_cycles", lowcnt, TAPS + 2 + hold);
        chk("m_valid_drop", 64'(m_valid), 0);
        chk("s_ready_back", 64'(s_ready), 1);
        chk("busy_idle", 64'(busy), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
`ifdef FIR_MAC_COEF_ERR_EN
        coef_err_clr = 1'b0;
`endif
        model_clear();
        step();
        step();

        // Reset state
        chk("rst_s_ready", 64'(s_ready), 1);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_m_data", m_data, 0);
        chk_bank("rst_prod", prod_flat, '0);
`ifdef FIR_MAC_COEF_ERR_EN
        chk("rst_coef_err", 64'(coef_err), 0);
`endif
        rst_n = 1'b1;
        step();

        // Impulse of 5 through all-ones coefficients
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'sd1);
        run_sample(16'sd5, 0, 1'b0, 1'b0);
        chk("impulse_result", m_data, 5);

        // Ramp coefficients k+1, samples 1..8; sample 3 sees dropped writes
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'(i + 1));
        for (int i = 1; i <= TAPS; i++) run_sample(16'(i), 0, 1'b0, i == 3);
        chk("ramp_result", m_data, 120);
`ifdef FIR_MAC_COEF_ERR_EN
        chk("coef_err_sticky", 64'(coef_err), 1);
        coef_err_clr = 1'b1;
        step();
        coef_err_clr = 1'b0;
        chk("coef_err_clr", 64'(coef_err), 0);
`endif

        // Downstream stall of 5 cycles
        run_sample(16'sd9, 5, 1'b0, 1'b0);

        // Most negative operands everywhere: no sign wrap in the sum
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), -16'sd32768);
        for (int i = 0; i < TAPS; i++) run_sample(-16'sd32768, 0, 1'b0, 1'b0);
        chk("max_neg_result", m_data, 64'sd8589934592);

        // Random coefficients, samples, stalls and accept-edge coefficient writes
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) write_coef(3'($urandom_range(0, TAPS - 1)), 16'($urandom));
            run_sample(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of MAC
        s_valid = 1'b1;
        s_data  = 16'sd5;
        step();
        s_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_m_valid", 64'(m_valid), 0);
        chk("midrst_s_ready", 64'(s_ready), 1);
        chk_bank("midrst_prod", prod_flat, '0);
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        run_sample(16'sd5, 0, 1'b0, 1'b0);
        chk("post_rst_result", m_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
